// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by both ends of the serial link
// (paralelo_serial transmitter and serial_paralelo receiver).
//   BYTE_W         - width of one symbol on the link
//   COM_SYMBOL_DEF - comma/idle byte sent while the transmitter has no data
//   state_e        - receiver alignment states
package serial_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam logic [7:0]  COM_SYMBOL_DEF = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,  // bit-level hunt for the comma
    SYNC   = 2'd1,  // byte-locked, counting consecutive commas
    ACTIVE = 2'd2   // link up, delivering bytes
  } state_e;

endpackage

// File: rtl/com_detector.sv
// com_detector: serial shift register plus comma compare.
//   clk_i, rst_ni - bit clock, async active-low reset
//   bit_i         - serial data, MSB first
//   nxt_o         - the byte the register will hold after this edge
//   is_com_o      - nxt_o equals COM_SYMBOL
module com_detector
  import serial_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_i,
  output logic [7:0] nxt_o,
  output logic       is_com_o
);

  logic [7:0] sr_q;

  // Look-ahead view: the decision on this edge includes the bit being sampled.
  assign nxt_o    = {sr_q[6:0], bit_i};
  assign is_com_o = (nxt_o == COM_SYMBOL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sr_q <= '0;
    else         sr_q <= nxt_o;
  end

endmodule

// File: rtl/serial_paralelo.sv
// serial_paralelo: serial-to-parallel receiver for the paralelo_serial link.
//   clk_32f   - bit clock, one bit per rising edge
//   reset     - async active-low reset
//   data_in   - serial data, MSB first
//   data_out  - last received non-comma byte
//   valid_out - data_out holds a new byte (one byte period)
//   idle_out  - last byte was the comma while ACTIVE (one byte period)
//   active    - link aligned and synchronized
module serial_paralelo
  import serial_pkg::*;
#(
  parameter logic [7:0]  COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int unsigned COM_COUNT  = 4   // 1..15
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       idle_out,
  output logic       active
);

  localparam logic [3:0] COM_CNT_L = COM_COUNT[3:0];

  logic [7:0] nxt;
  logic       is_com;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       idle_q, idle_d;
  logic       active_q, active_d;
  logic       byte_done;

  com_detector #(.COM_SYMBOL(COM_SYMBOL)) u_com (
    .clk_i   (clk_32f),
    .rst_ni  (reset),
    .bit_i   (data_in),
    .nxt_o   (nxt),
    .is_com_o(is_com)
  );

  // bit_cnt==7 marks the edge that samples the LSB of the aligned byte.
  assign byte_done = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    idle_d    = idle_q;
    active_d  = active_q;
    case (state_q)
      SEARCH: begin
        if (is_com) begin
          // The comma just ended on this edge: that is the byte boundary.
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          if (COM_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q + 4'd1 == COM_CNT_L) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // Alignment was a false comma (or the run broke): hunt again.
            state_d   = SEARCH;
            com_cnt_d = 4'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (is_com) begin
            idle_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
            idle_d  = 1'b0;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idle_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idle_q    <= idle_d;
      active_q  <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign idle_out  = idle_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: a COM_COUNT=4 and a COM_COUNT=1 instance
// compared against a window-scan model of the received bit history.
module tb_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0, data_in1 = 1'b0;
  logic [7:0] data_out, data_out1;
  logic       valid_out, idle_out, active;
  logic       valid_out1, idle_out1, active1;
  logic [10:0] obs0, obs1;

  int checks = 0;
  int errors = 0;

  bit q0[$];
  bit q1[$];

  assign obs0 = {active,  valid_out,  idle_out,  data_out};
  assign obs1 = {active1, valid_out1, idle_out1, data_out1};

  always #5 clk_32f = ~clk_32f;

  serial_paralelo dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .idle_out(idle_out), .active(active)
  );

  serial_paralelo #(.COM_COUNT(1)) dut1 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in1),
    .data_out(data_out1), .valid_out(valid_out1), .idle_out(idle_out1), .active(active1)
  );

  // 8-bit window of the received history ending at bit i (zeros before reset release).
  function automatic logic [7:0] win(input int sel, input int i);
    logic [7:0] w;
    logic b;
    w = '0;
    for (int k = i - 7; k <= i; k++) begin
      b = 1'b0;
      if (k >= 0) b = (sel == 0) ? q0[k] : q1[k];
      w = {w[6:0], b};
    end
    return w;
  endfunction

  // Expected {active, valid, idle, data} after the bits received so far.
  // Lock: a comma window at p, confirmed by cc-1 further commas every 8 bits;
  // a broken run resumes the hunt one bit after the offending byte.
  function automatic logic [10:0] model(input int sel, input int cc);
    int n, pos, lock, fail;
    bit ok, pend;
    logic v, id;
    logic [7:0] d, w;
    n    = (sel == 0) ? q0.size() : q1.size();
    pos  = 0;
    lock = -1;
    pend = 0;
    while (pos < n && lock < 0 && !pend) begin
      if (win(sel, pos) == 8'hBC) begin
        ok = 1; fail = 0;
        for (int k = 1; k < cc; k++) begin
          if (ok) begin
            if (pos + 8*k >= n) begin ok = 0; pend = 1; end
            else if (win(sel, pos + 8*k) != 8'hBC) begin ok = 0; fail = pos + 8*k; end
          end
        end
        if (ok) lock = pos + 8*(cc-1);
        else if (!pend) pos = fail + 1;
      end else begin
        pos++;
      end
    end
    if (lock < 0) return 11'h000;
    v = 0; id = 0; d = 8'h00;
    for (int c = lock + 8; c < n; c += 8) begin
      w = win(sel, c);
      if (w == 8'hBC) begin id = 1; v = 0; end
      else begin d = w; v = 1; id = 0; end
    end
    return {1'b1, v, id, d};
  endfunction

  task automatic send_bit(input logic b0, input logic b1);
    @(negedge clk_32f);
    data_in  = b0;
    data_in1 = b1;
    @(posedge clk_32f);
    if (reset) begin
      q0.push_back(b0);
      q1.push_back(b1);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] bc;
    bc = 8'hBC;
    reset = 1'b0;
    q0.delete(); q1.delete();
    for (int i = 0; i < 20; i++) begin
      send_bit(1'($urandom), 1'($urandom));
      checks++;
      if (obs0 !== 11'h000 || obs1 !== 11'h000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %h/%h want 000", i, obs0, obs1);
      end
    end
    @(negedge clk_32f);
    reset = 1'b1;
    for (int k = 0; k < 5; k++)
      for (int j = 7; j >= 0; j--) begin
        send_bit(bc[j], 1'b0);
        if (k == 3 && j <= 1) begin
          checks++;
          if (active !== (j == 0)) begin
            errors++;
            $display("FAIL lock_edge bit %0d: active got %b want %b", j, active, j == 0);
          end
        end
      end
    checks++;
    if (obs0 !== {1'b1, 1'b0, 1'b1, 8'h00} || obs0 !== model(0, 4)) begin
      errors++;
      $display("FAIL idle_after_lock: got %h want %h", obs0, {1'b1, 1'b0, 1'b1, 8'h00});
    end
  endtask

  task automatic test_misalign();
    logic [7:0] bytes [5];
    bytes = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h5A};
    do_reset();
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 7; j >= 0; j--) send_bit(bytes[k][j], 1'b0);
      checks++;
      if (active !== (k >= 3)) begin
        errors++;
        $display("FAIL misalign_active byte %0d: got %b want %b", k, active, k >= 3);
      end
    end
    checks++;
    if (obs0 !== {1'b1, 1'b1, 1'b0, 8'h5A} || obs0 !== model(0, 4)) begin
      errors++;
      $display("FAIL misalign_data: got %h want %h", obs0, {1'b1, 1'b1, 1'b0, 8'h5A});
    end
  endtask

  task automatic test_short_run();
    logic [7:0] bytes [9];
    bytes = '{8'hBC, 8'hBC, 8'hBC, 8'hAA, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int j = 7; j >= 0; j--) send_bit(bytes[k][j], 1'b0);
      checks++;
      if (active !== (k >= 7) || obs0 !== model(0, 4)) begin
        errors++;
        $display("FAIL short_run byte %0d: got %h want active=%b model %h", k, obs0, k >= 7, model(0, 4));
      end
    end
    checks++;
    if (obs0 !== {1'b1, 1'b1, 1'b0, 8'h33}) begin
      errors++;
      $display("FAIL short_run_data: got %h want %h", obs0, {1'b1, 1'b1, 1'b0, 8'h33});
    end
  endtask

  task automatic test_full_link();
    logic [7:0]  tx  [12];
    logic [10:0] exp [12];
    logic [10:0] want;
    tx  = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hCC, 8'hAA, 8'hCC, 8'hAA, 8'hBC, 8'hAA, 8'hCC};
    exp = '{11'h000, 11'h000, 11'h000, 11'h400, 11'h500, 11'h6CC,
            11'h6AA, 11'h6CC, 11'h6AA, 11'h5AA, 11'h6AA, 11'h6CC};
    do_reset();
    for (int k = 0; k < 12; k++)
      for (int j = 7; j >= 0; j--) begin
        send_bit(tx[k][j], 1'b0);
        want = (j == 0) ? exp[k] : ((k > 0) ? exp[k-1] : 11'h000);
        checks++;
        if (obs0 !== want) begin
          errors++;
          $display("FAIL full_link byte %0d bit %0d: got %h want %h", k, j, obs0, want);
        end
      end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [9];
    bytes = '{8'hBC, 8'hBC, 8'hBC, 8'h77, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h77};
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int j = 7; j >= 0; j--) send_bit(bytes[0][j], 1'b0);
    for (int j = 7; j >= 4; j--) send_bit(bytes[3][j], 1'b0);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: active got %b want 1", active);
    end
    @(negedge clk_32f);
    #1 reset = 1'b0;
    q0.delete(); q1.delete();
    #1;
    checks++;
    if (obs0 !== 11'h000) begin
      errors++;
      $display("FAIL mid_async: got %h want 000", obs0);
    end
    @(negedge clk_32f);
    reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int j = 7; j >= 0; j--) begin
        send_bit(bytes[k][j], 1'b0);
        if (k < 7) begin
          checks++;
          if (valid_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL mid_relock byte %0d bit %0d: valid %b active %b want 0 0", k, j, valid_out, active);
          end
        end
      end
    end
    checks++;
    if (obs0 !== {1'b1, 1'b1, 1'b0, 8'h77}) begin
      errors++;
      $display("FAIL mid_data: got %h want %h", obs0, {1'b1, 1'b1, 1'b0, 8'h77});
    end
  endtask

  task automatic test_com1();
    logic [7:0] b;
    do_reset();
    b = 8'hBC;
    for (int j = 7; j >= 0; j--) send_bit(1'b0, b[j]);
    checks++;
    if (obs1 !== 11'h400) begin
      errors++;
      $display("FAIL com1_lock: got %h want 400", obs1);
    end
    b = 8'h12;
    for (int j = 7; j >= 0; j--) send_bit(1'b0, b[j]);
    checks++;
    if (obs1 !== {1'b1, 1'b1, 1'b0, 8'h12} || obs1 !== model(1, 1)) begin
      errors++;
      $display("FAIL com1_data: got %h want %h", obs1, {1'b1, 1'b1, 1'b0, 8'h12});
    end
  endtask

  // Random streams: comma runs, random bytes and bit slips, checked every edge.
  task automatic test_random();
    logic [7:0] b0s [$];
    logic [7:0] b1s [$];
    logic [7:0] bv;
    int r, lim;
    logic [10:0] e0, e1;
    for (int rnd = 0; rnd < 6; rnd++) begin
      do_reset();
      for (int c = 0; c < 14; c++) begin
        b0s.delete(); b1s.delete();
        r = $urandom_range(0, 9);
        if (r < 4) begin
          lim = $urandom_range(2, 5);
          for (int i = 0; i < lim; i++) begin b0s.push_back(8'hBC); b1s.push_back(8'hBC); end
        end else begin
          bv = 8'($urandom); b0s.push_back(bv);
          bv = 8'($urandom); b1s.push_back(bv);
        end
        foreach (b0s[i])
          for (int j = 7; j >= 0; j--) begin
            send_bit(b0s[i][j], b1s[i][j]);
            e0 = model(0, 4);
            e1 = model(1, 1);
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
              errors++;
              $display("FAIL random rnd %0d: got %h/%h want %h/%h", rnd, obs0, obs1, e0, e1);
            end
          end
        if (r == 9) begin
          lim = $urandom_range(1, 3);
          for (int i = 0; i < lim; i++) send_bit(1'($urandom), 1'($urandom));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_misalign();
    test_short_run();
    test_full_link();
    test_reset_mid();
    test_com1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
